button_encoder: RTL



---
 rtl/button_encoder.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/button_encoder.sv
// button_encoder
//   Conditions the eight raw player buttons and turns each clean, single-button
//   press into a one-cycle 3-bit symbol strobe for the input handler.
//   Path: 2-flop synchronizer -> debounce (DEBOUNCE_CYCLES identical samples)
//   -> press FSM (IDLE / HELD / REJECT) with registered outputs.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive identical synchronized samples before a
//                    button vector becomes stable (>= 2)
//   CNT_W            debounce counter width (2**CNT_W > DEBOUNCE_CYCLES)
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   en         accept presses (sampled only when leaving IDLE)
//   btn_raw    asynchronous button levels, bit i = symbol i, 1 = pressed
//   sym        index of the last accepted button (holds between strobes)
//   sym_valid  one-cycle strobe: sym is new
//   multi_err  one-cycle strobe: chorded press rejected
//   busy       high while the FSM is not in IDLE
module button_encoder #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] btn_raw,
  output logic [2:0] sym,
  output logic       sym_valid,
  output logic       multi_err,
  output logic       busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    REJECT
  } state_t;

  logic [7:0]       sync_p0;
  logic [7:0]       sync_p1;
  logic [7:0]       cand;
  logic [7:0]       stable;
  logic [CNT_W-1:0] cnt;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] held;
  logic [7:0] held_nxt;
  logic [2:0] sym_nxt;
  logic       sym_valid_nxt;
  logic       multi_err_nxt;

  function automatic logic is_one_hot(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

  function automatic logic [2:0] encode(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Stage boundary: synchronizer and debounce
  // A change in the synchronized vector restarts the count; once the count
  // reaches its last value it parks there and keeps reloading stable, so a
  // long hold costs nothing and any glitch shorter than the window is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 8'd0;
      sync_p1 <= 8'd0;
      cand    <= 8'd0;
      cnt     <= '0;
      stable  <= 8'd0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
      if (sync_p1 != cand) begin
        cand <= sync_p1;
        cnt  <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= cand;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Stage boundary: press FSM next-state / next-output
  // held remembers the accepted button so that any newly added button while
  // holding it is recognised as a chord and parked in REJECT without a strobe.
  always_comb begin
    state_nxt     = state;
    held_nxt      = held;
    sym_nxt       = sym;
    sym_valid_nxt = 1'b0;
    multi_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (stable != 8'd0) begin
          if (is_one_hot(stable)) begin
            state_nxt = HELD;
            held_nxt  = stable;
            if (en) begin
              sym_valid_nxt = 1'b1;
              sym_nxt       = encode(stable);
            end
          end else begin
            state_nxt     = REJECT;
            multi_err_nxt = en;
          end
        end
      end
      HELD: begin
        if (stable == 8'd0) begin
          state_nxt = IDLE;
        end else if ((stable & ~held) != 8'd0) begin
          state_nxt = REJECT;
        end
      end
      REJECT: begin
        if (stable == 8'd0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage boundary: registered FSM state and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      held      <= 8'd0;
      sym       <= 3'd0;
      sym_valid <= 1'b0;
      multi_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      held      <= held_nxt;
      sym       <= sym_nxt;
      sym_valid <= sym_valid_nxt;
      multi_err <= multi_err_nxt;
      busy      <= (state_nxt != IDLE);
    end
  end

endmodule
